// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// instruction-fetch and data-access requesters. Data has fixed priority.
// Optional feature macro: MEMARB_RDATA_HOLD_EN registers the read data
// outputs so they hold the last completed value per requester.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_iReq,
  input  logic [ADDR_W-1:0] i_iAddr,
  input  logic              i_iFlush,
  output logic [DATA_W-1:0] o_iRdata,
  output logic              o_iValid,
  output logic              o_iStall,
  input  logic              i_dReq,
  input  logic              i_dWrite,
  input  logic [1:0]        i_dSize,
  input  logic [ADDR_W-1:0] i_dAddr,
  input  logic [DATA_W-1:0] i_dWdata,
  output logic [DATA_W-1:0] o_dRdata,
  output logic              o_dValid,
  output logic              o_dStall,
  output logic              o_memReq,
  output logic              o_memWrite,
  output logic [1:0]        o_memSize,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWdata,
  input  logic              i_memReady,
  input  logic [DATA_W-1:0] i_memRdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t state;
  logic   drop;

  logic i_done;
  logic d_done;
  logic i_hit;
  logic arb_en;
  logic d_win;
  logic i_win;

  // Completion decode; a flush coincident with completion also discards the fetch
  assign i_done = (state == I_BUSY) && i_memReady;
  assign d_done = (state == D_BUSY) && i_memReady;
  assign i_hit  = i_done && !drop && !i_iFlush;

  assign o_iValid = !reset && i_hit;
  assign o_dValid = !reset && d_done;
  assign o_iStall = !reset && i_iReq && !i_hit;
  assign o_dStall = !reset && i_dReq && !d_done;

  // Arbitrate in IDLE or on completion. A requester just served still holds
  // its request this cycle, so it sits out; a dropped fetch has not been
  // served and may reissue at once to the redirect address.
  assign arb_en = (state == IDLE) || i_done || d_done;
  assign d_win  = arb_en && i_dReq && !d_done;
  assign i_win  = arb_en && !d_win && i_iReq && !i_hit;

  // Port FSM with registered memory-side outputs and the fetch drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      drop       <= 1'b0;
      o_memReq   <= 1'b0;
      o_memWrite <= 1'b0;
      o_memSize  <= 2'b00;
      o_memAddr  <= '0;
      o_memWdata <= '0;
    end else if (d_win) begin
      state      <= D_BUSY;
      drop       <= 1'b0;
      o_memReq   <= 1'b1;
      o_memWrite <= i_dWrite;
      o_memSize  <= i_dSize;
      o_memAddr  <= i_dAddr;
      o_memWdata <= i_dWdata;
    end else if (i_win) begin
      state      <= I_BUSY;
      drop       <= i_iFlush;
      o_memReq   <= 1'b1;
      o_memWrite <= 1'b0;
      o_memSize  <= 2'b10;
      o_memAddr  <= i_iAddr;
      o_memWdata <= '0;
    end else if (arb_en) begin
      state    <= IDLE;
      drop     <= 1'b0;
      o_memReq <= 1'b0;
    end else if ((state == I_BUSY) && i_iFlush) begin
      drop <= 1'b1;
    end
  end

`ifdef MEMARB_RDATA_HOLD_EN
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;

  // Capture read data on each requester's own delivered completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      if (i_hit)  irdata_q <= i_memRdata;
      if (d_done) drdata_q <= i_memRdata;
    end
  end

  assign o_iRdata = irdata_q;
  assign o_dRdata = drdata_q;
`else
  assign o_iRdata = i_memRdata;
  assign o_dRdata = i_memRdata;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: cycle vectors for timing plus a scoreboard for issued
// transactions and returned read data; a hand sequence covers async reset.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_iReq;
  logic [31:0] i_iAddr;
  logic        i_iFlush;
  logic [31:0] o_iRdata;
  logic        o_iValid;
  logic        o_iStall;
  logic        i_dReq;
  logic        i_dWrite;
  logic [1:0]  i_dSize;
  logic [31:0] i_dAddr;
  logic [31:0] i_dWdata;
  logic [31:0] o_dRdata;
  logic        o_dValid;
  logic        o_dStall;
  logic        o_memReq;
  logic        o_memWrite;
  logic [1:0]  o_memSize;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWdata;
  logic        i_memReady;
  logic [31:0] i_memRdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_iReq(i_iReq), .i_iAddr(i_iAddr), .i_iFlush(i_iFlush),
    .o_iRdata(o_iRdata), .o_iValid(o_iValid), .o_iStall(o_iStall),
    .i_dReq(i_dReq), .i_dWrite(i_dWrite), .i_dSize(i_dSize),
    .i_dAddr(i_dAddr), .i_dWdata(i_dWdata),
    .o_dRdata(o_dRdata), .o_dValid(o_dValid), .o_dStall(o_dStall),
    .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memSize(o_memSize),
    .o_memAddr(o_memAddr), .o_memWdata(o_memWdata),
    .i_memReady(i_memReady), .i_memRdata(i_memRdata)
  );

  always #10 clk = ~clk;

  // One cycle of stimulus plus the outputs expected in that cycle.
  // iss: 0 none, 1 fetch issued and delivered, 2 fetch issued but dropped,
  //      3 data issued and completed, 4 data issued then abandoned.
  typedef struct {
    logic        ireq;  logic [31:0] iaddr; logic iflush;
    logic        dreq;  logic dwr; logic [1:0] dsz; logic [31:0] daddr; logic [31:0] dwd;
    int          wt;    int iss;
    logic        mreq;  logic [31:0] maddr; logic ival; logic dval; logic istall; logic dstall;
  } vec_t;

  typedef struct {
    logic [31:0] addr; logic wr; logic [1:0] sz; logic [31:0] wd;
  } iss_t;

  vec_t        vq[$];
  iss_t        iss_q[$];
  logic [31:0] ird_q[$];
  logic [31:0] drd_q[$];

  int n_vec;
  int n_err;
  int mem_wait;
  int wcnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a == 32'h0000_3000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_missing(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: DUT event with no expectation queued at %0t", nm, $time);
  endtask

  task automatic push_issue(input int kind);
    iss_t e;
    if (kind == 1 || kind == 2) begin
      e.addr = i_iAddr; e.wr = 1'b0; e.sz = 2'b10; e.wd = 32'h0;
      iss_q.push_back(e);
      if (kind == 1) ird_q.push_back(mem_rd(i_iAddr));
    end else if (kind == 3 || kind == 4) begin
      e.addr = i_dAddr; e.wr = i_dWrite; e.sz = i_dSize; e.wd = i_dWdata;
      iss_q.push_back(e);
      if (kind == 3) drd_q.push_back(mem_rd(i_dAddr));
    end
  endtask

  // Memory model: completes after mem_wait extra cycles, shares the reset
  always @(negedge clk) begin
    #1;
    if (reset) begin
      wcnt = 0;
      i_memReady = 1'b0;
    end else if (o_memReq) begin
      i_memReady = (wcnt >= mem_wait);
      wcnt = i_memReady ? 0 : wcnt + 1;
    end else begin
      wcnt = 0;
      i_memReady = 1'b0;
    end
    i_memRdata = i_memReady ? mem_rd(o_memAddr) : 32'h0BAD_0BAD;
  end

  // Scoreboard: pop on each new transaction and each valid pulse
  logic        prev_req;
  logic        prev_rdy;
  logic [31:0] hd_i;
  logic [31:0] hd_d;

  always @(negedge clk) begin
    iss_t        e;
    logic [31:0] r;
    #3;
    if (reset) begin
      prev_req = 1'b0; prev_rdy = 1'b0; hd_i = 32'h0; hd_d = 32'h0;
    end else begin
      if (o_memReq && (!prev_req || prev_rdy)) begin
        if (iss_q.size() == 0) chk_missing("issue");
        else begin
          e = iss_q.pop_front();
          chk("issue_addr", o_memAddr, e.addr);
          chk("issue_ctl", 32'({o_memWrite, o_memSize}), 32'({e.wr, e.sz}));
          chk("issue_wdata", o_memWdata, e.wd);
        end
      end
`ifdef MEMARB_RDATA_HOLD_EN
      chk("irdata_hold", o_iRdata, hd_i);
      chk("drdata_hold", o_dRdata, hd_d);
`endif
      if (o_iValid) begin
        if (ird_q.size() == 0) chk_missing("ivalid");
        else begin
          r = ird_q.pop_front();
`ifdef MEMARB_RDATA_HOLD_EN
          hd_i = r;
`else
          chk("irdata", o_iRdata, r);
`endif
        end
      end
      if (o_dValid) begin
        if (drd_q.size() == 0) chk_missing("dvalid");
        else begin
          r = drd_q.pop_front();
`ifdef MEMARB_RDATA_HOLD_EN
          hd_d = r;
`else
          chk("drdata", o_dRdata, r);
`endif
        end
      end
      prev_req = o_memReq;
      prev_rdy = i_memReady;
    end
  end

  initial begin
    vec_t v;
    n_vec = 0; n_err = 0; mem_wait = 0;

    // ireq, iaddr, iflush, dreq, dwr, dsz, daddr, dwd, wt, iss | mreq, maddr, ival, dval, istall, dstall
    // single fetch, memory always ready
    vq.push_back('{1'b1,32'h100,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,1, 1'b0,32'h0,  1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h100,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b1,32'h100,1'b1,1'b0,1'b0,1'b0});
    vq.push_back('{1'b0,32'h0,  1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b0,32'h100,1'b0,1'b0,1'b0,1'b0});
    // both requests: store wins, 3 wait cycles, fetch follows with no bubble
    vq.push_back('{1'b1,32'h104,1'b0, 1'b1,1'b1,2'b01,32'h2000,32'h12345678, 3,3, 1'b0,32'h100, 1'b0,1'b0,1'b1,1'b1});
    vq.push_back('{1'b1,32'h104,1'b0, 1'b1,1'b1,2'b01,32'h2000,32'h12345678, 3,0, 1'b1,32'h2000,1'b0,1'b0,1'b1,1'b1});
    vq.push_back('{1'b1,32'h104,1'b0, 1'b1,1'b1,2'b01,32'h2000,32'h12345678, 3,0, 1'b1,32'h2000,1'b0,1'b0,1'b1,1'b1});
    vq.push_back('{1'b1,32'h104,1'b0, 1'b1,1'b1,2'b01,32'h2000,32'h12345678, 3,0, 1'b1,32'h2000,1'b0,1'b0,1'b1,1'b1});
    vq.push_back('{1'b1,32'h104,1'b0, 1'b1,1'b1,2'b01,32'h2000,32'h12345678, 3,1, 1'b1,32'h2000,1'b0,1'b1,1'b1,1'b0});
    vq.push_back('{1'b1,32'h104,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b1,32'h104,1'b1,1'b0,1'b0,1'b0});
    vq.push_back('{1'b0,32'h0,  1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b0,32'h104,1'b0,1'b0,1'b0,1'b0});
    // flush one cycle after issue; redirect fetch issues in the completion cycle
    vq.push_back('{1'b1,32'h200,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 2,2, 1'b0,32'h104,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h300,1'b1, 1'b0,1'b0,2'b00,32'h0,32'h0, 2,0, 1'b1,32'h200,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h300,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 2,0, 1'b1,32'h200,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h300,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 2,1, 1'b1,32'h200,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h300,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b1,32'h300,1'b1,1'b0,1'b0,1'b0});
    vq.push_back('{1'b0,32'h0,  1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b0,32'h300,1'b0,1'b0,1'b0,1'b0});
    // flush coincident with ready; the next fetch must be delivered
    vq.push_back('{1'b1,32'h400,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 1,2, 1'b0,32'h300,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h400,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 1,0, 1'b1,32'h400,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b0,32'h0,  1'b1, 1'b0,1'b0,2'b00,32'h0,32'h0, 1,0, 1'b1,32'h400,1'b0,1'b0,1'b0,1'b0});
    vq.push_back('{1'b1,32'h500,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,1, 1'b0,32'h400,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h500,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b1,32'h500,1'b1,1'b0,1'b0,1'b0});
    // load of 0xDEADBEEF, flush in IDLE and D_BUSY ignored, then a fetch
    vq.push_back('{1'b0,32'h0,  1'b1, 1'b1,1'b0,2'b10,32'h3000,32'h0, 1,3, 1'b0,32'h500,1'b0,1'b0,1'b0,1'b1});
    vq.push_back('{1'b1,32'h600,1'b1, 1'b1,1'b0,2'b10,32'h3000,32'h0, 1,0, 1'b1,32'h3000,1'b0,1'b0,1'b1,1'b1});
    vq.push_back('{1'b1,32'h600,1'b0, 1'b1,1'b0,2'b10,32'h3000,32'h0, 1,1, 1'b1,32'h3000,1'b0,1'b1,1'b1,1'b0});
    vq.push_back('{1'b1,32'h600,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b1,32'h600,1'b1,1'b0,1'b0,1'b0});
    vq.push_back('{1'b0,32'h0,  1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b0,32'h600,1'b0,1'b0,1'b0,1'b0});
    // data arrives during a fetch and wins at fetch completion
    vq.push_back('{1'b1,32'h700,1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 1,1, 1'b0,32'h600,1'b0,1'b0,1'b1,1'b0});
    vq.push_back('{1'b1,32'h700,1'b0, 1'b1,1'b1,2'b00,32'h2004,32'hA5, 1,0, 1'b1,32'h700,1'b0,1'b0,1'b1,1'b1});
    vq.push_back('{1'b1,32'h700,1'b0, 1'b1,1'b1,2'b00,32'h2004,32'hA5, 1,3, 1'b1,32'h700,1'b1,1'b0,1'b0,1'b1});
    vq.push_back('{1'b0,32'h0,  1'b0, 1'b1,1'b1,2'b00,32'h2004,32'hA5, 0,0, 1'b1,32'h2004,1'b0,1'b1,1'b0,1'b0});
    vq.push_back('{1'b0,32'h0,  1'b0, 1'b0,1'b0,2'b00,32'h0,32'h0, 0,0, 1'b0,32'h2004,1'b0,1'b0,1'b0,1'b0});

    // reset with both requests raised: everything must read zero
    reset = 1'b1;
    i_iReq = 1'b1; i_iAddr = 32'h0; i_iFlush = 1'b0;
    i_dReq = 1'b1; i_dWrite = 1'b0; i_dSize = 2'b00; i_dAddr = 32'h0; i_dWdata = 32'h0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_memReq", 32'(o_memReq), 32'h0);
    chk("rst_memCtl", 32'({o_memWrite, o_memSize}), 32'h0);
    chk("rst_memAddr", o_memAddr, 32'h0);
    chk("rst_memWdata", o_memWdata, 32'h0);
    chk("rst_valids", 32'({o_iValid, o_dValid}), 32'h0);
    chk("rst_stalls", 32'({o_iStall, o_dStall}), 32'h0);
    @(negedge clk);
    reset = 1'b0; i_iReq = 1'b0; i_dReq = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      v = vq[k];
      @(negedge clk);
      i_iReq = v.ireq; i_iAddr = v.iaddr; i_iFlush = v.iflush;
      i_dReq = v.dreq; i_dWrite = v.dwr; i_dSize = v.dsz; i_dAddr = v.daddr; i_dWdata = v.dwd;
      mem_wait = v.wt;
      push_issue(v.iss);
      #2;
      chk($sformatf("v%0d_memReq", k), 32'(o_memReq), 32'(v.mreq));
      chk($sformatf("v%0d_memAddr", k), o_memAddr, v.maddr);
      chk($sformatf("v%0d_iValid", k), 32'(o_iValid), 32'(v.ival));
      chk($sformatf("v%0d_dValid", k), 32'(o_dValid), 32'(v.dval));
      chk($sformatf("v%0d_iStall", k), 32'(o_iStall), 32'(v.istall));
      chk($sformatf("v%0d_dStall", k), 32'(o_dStall), 32'(v.dstall));
    end

    // asynchronous reset in D_BUSY abandons the store
    @(negedge clk);
    i_iReq = 1'b0; i_iFlush = 1'b0;
    i_dReq = 1'b1; i_dWrite = 1'b1; i_dSize = 2'b11; i_dAddr = 32'h2010; i_dWdata = 32'hCAFE_F00D;
    mem_wait = 3;
    push_issue(4);
    #2 chk("arst_idle_first", 32'(o_memReq), 32'h0);
    @(negedge clk);
    #2 chk("arst_busy", 32'(o_memReq), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_memReq", 32'(o_memReq), 32'h0);
    chk("arst_memCtl", 32'({o_memWrite, o_memSize}), 32'h0);
    chk("arst_memAddr", o_memAddr, 32'h0);
    chk("arst_memWdata", o_memWdata, 32'h0);
    chk("arst_dStall", 32'(o_dStall), 32'h0);
    chk("arst_dValid", 32'(o_dValid), 32'h0);
    @(negedge clk);
    #2 chk("arst_held", 32'(o_memReq), 32'h0);
    @(negedge clk);
    reset = 1'b0; i_dReq = 1'b0;
    #2 chk("arst_release", 32'(o_memReq), 32'h0);
    @(negedge clk);
    i_iReq = 1'b1; i_iAddr = 32'h800; mem_wait = 0;
    push_issue(1);
    #2;
    chk("post_rst_idle", 32'(o_memReq), 32'h0);
    chk("post_rst_iStall", 32'(o_iStall), 32'h1);
    @(negedge clk);
    #2;
    chk("post_rst_memReq", 32'(o_memReq), 32'h1);
    chk("post_rst_memAddr", o_memAddr, 32'h800);
    chk("post_rst_iValid", 32'(o_iValid), 32'h1);
    @(negedge clk);
    i_iReq = 1'b0;
    #2 chk("post_rst_done", 32'(o_memReq), 32'h0);
    repeat (2) @(negedge clk);
    #5;
    chk("iss_q_drained", 32'(iss_q.size()), 32'h0);
    chk("ird_q_drained", 32'(ird_q.size()), 32'h0);
    chk("drd_q_drained", 32'(drd_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single variable-latency memory port between the instruction-fetch (IF) and data-access (MEM) requesters of the 5-stage pipeline. Data accesses have fixed priority over fetches. The block drives per-requester stall signals into the hazard unit and returns read data with a one-cycle valid pulse. It sits between the datapath/controller (memory-control signals from the EX/MEM register) and the external memory handshake.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `i_iReq` input 1: fetch request. Level-held while the IF stage is stalled.
- `i_iAddr` input ADDR_W: fetch address (PC).
- `i_iFlush` input 1: fetch redirect (branch, jal, jalr, ecall, mret). The outstanding fetch is discarded.
- `o_iRdata` output DATA_W: fetched instruction.
- `o_iValid` output 1: fetch completes this cycle.
- `o_iStall` output 1: `i_iReq && !o_iValid`.
- `i_dReq` input 1: data request (`Mo_memReq`).
- `i_dWrite` input 1: store (`Mo_memWrite`).
- `i_dSize` input 2: access size (`Mo_memSize`).
- `i_dAddr` input ADDR_W: data address.
- `i_dWdata` input DATA_W: store data.
- `o_dRdata` output DATA_W: load data.
- `o_dValid` output 1: data access completes this cycle.
- `o_dStall` output 1: `i_dReq && !o_dValid`.
- `o_memReq` output 1: registered. Memory transaction in progress.
- `o_memWrite` output 1: registered.
- `o_memSize` output 2: registered.
- `o_memAddr` output ADDR_W: registered.
- `o_memWdata` output DATA_W: registered.
- `i_memReady` input 1: memory completes the current transaction this cycle.
- `i_memRdata` input DATA_W: read data. Valid only when `i_memReady` is 1.

## Operation
- FSM states:
  - IDLE: `o_memReq`=0.
  - I_BUSY: fetch in flight.
  - D_BUSY: data access in flight.
- Arbitration:
  - Evaluated in IDLE and in the completion cycle of either busy state.
  - Fixed priority: eligible `i_dReq` first, then eligible `i_iReq`.
  - A requester whose transaction completes in the current cycle is not eligible in that cycle, because its request is still held.
- Issue:
  - The winner's address, size, write flag and write data are latched into the `o_mem*` registers.
  - `o_memReq` rises the next cycle. The state moves to the matching busy state.
  - Fetch issues as a word read: `o_memWrite`=0, `o_memSize`=2'b10.
- Busy:
  - `o_mem*` are held stable until `i_memReady`=1.
  - On `i_memReady`: pulse `o_iValid` or `o_dValid` for one cycle.
  - Then re-arbitrate: go to the next busy state with new `o_mem*`, or to IDLE with `o_memReq`=0.
- Flush:
  - `i_iFlush` in I_BUSY, or in the cycle I_BUSY is entered, sets the `drop` flag.
  - The memory transaction still completes and cannot be aborted. `o_iValid` is suppressed for it, and `drop` clears at completion.
  - `i_iFlush` in IDLE or D_BUSY has no effect.
  - `o_iStall` follows its equation unchanged while a dropped transaction is in flight.
- Simultaneous `i_iFlush` and `i_memReady` in I_BUSY: the completion is dropped and `o_iValid`=0.
- Requests deasserted while busy do not cancel the in-flight transaction. The result is discarded silently.
- Reset:
  - State IDLE, `drop`=0.
  - All registered outputs 0: `o_memReq`, `o_memWrite`, `o_memSize`, `o_memAddr`, `o_memWdata`.
  - `o_iValid`, `o_dValid` and both stalls are 0 while in reset.
  - Reset mid-transaction abandons the transaction. Memory shares the same reset.

## Timing
- Minimum latency is 2 cycles, from a request seen in IDLE to valid: issue cycle, then memory cycle with `i_memReady`=1.
- Each extra wait cycle at the memory adds 1 cycle.
- Back-to-back transactions have no idle bubble: the next `o_memReq` is high the cycle after completion.
- `o_iValid`, `o_dValid`, `o_*Rdata` and the stalls are combinational from `i_memReady`, `i_memRdata` and state.

## Configuration
- `MEMARB_RDATA_HOLD_EN` defined:
  - `o_iRdata` and `o_dRdata` are DATA_W registers.
  - Each loads `i_memRdata` on its own valid completion and holds the value until the next one. Reset value is 0.
  - The value is visible from the cycle after valid.
  - `o_*Valid` timing is unchanged: it still pulses in the completion cycle. Consumers sample the data one cycle later.
- Undefined: `o_iRdata` and `o_dRdata` are wired directly to `i_memRdata`. They are meaningful only in the valid cycle.

## Test plan
- Single fetch, `i_memReady` tied 1, `i_iAddr`=0x100 -> `o_memReq`=1 and `o_memAddr`=0x100 in cycle 1; `o_iValid`=1 in cycle 1 with `o_iRdata`=`i_memRdata`; `o_iStall`=1 in cycle 0 only.
- `i_iReq` and `i_dReq` both high in IDLE, store to 0x2000 with `i_dSize`=2'b01 and 3 memory wait cycles -> data issues first and `o_dValid` arrives after 4 memory cycles; fetch issues the next cycle with no bubble.
- `i_iFlush` pulse one cycle after fetch issue, memory ready 2 cycles later -> `o_iValid` stays 0; a new fetch to the redirect address issues immediately after.
- `i_iFlush` coincident with `i_memReady` in I_BUSY -> no `o_iValid`; `drop` is 0 afterwards.
- `reset` asserted asynchronously in D_BUSY -> `o_memReq`=0 and all `o_mem*`=0 immediately; state is IDLE after release.
- `MEMARB_RDATA_HOLD_EN` defined, load returns 0xDEADBEEF -> `o_dRdata`=0xDEADBEEF from the cycle after `o_dValid` and held through a following fetch.
